// File: rtl/mips_mem_pkg.sv
// Shared MIPS load/store definitions: opcodes, LSU state encoding, byte-enable patterns
// and small decode helpers used by both the controller and the lane aligner.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    // Lane k occupies bits 8k+7:8k, so byte enable bit k selects that lane.
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic addr_is_aligned(input logic [5:0] op, input logic [1:0] lsb);
        case (op)
            OP_LH, OP_LHU, OP_SH: return ~lsb[0];
            OP_LW, OP_SW:         return (lsb == 2'b00);
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] steered_data,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte    = load_word[{byte_sel, 3'b000} +: 8];
        lane_half    = byte_sel[1] ? load_word[31:16] : load_word[15:0];
        be           = BE_WORD;
        steered_data = store_data;
        load_data    = load_word;
        case (opcode)
            OP_SB: begin
                be           = BE_BYTE0 << byte_sel;
                steered_data = {4{store_data[7:0]}};
            end
            OP_SH: begin
                be           = byte_sel[1] ? BE_HALF_HI : BE_HALF_LO;
                steered_data = {2{store_data[15:0]}};
            end
            OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data = {24'h0, lane_byte};
            OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data = {16'h0, lane_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding MIPS load/store controller: accepts one request, issues one memory
// access with a bounded wait for ack, then returns a one-cycle response.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state, state_n;
    logic [5:0]       op_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    logic [31:0] ea;
    logic        req_ok;
    logic        issuing;
    logic        timed_out;
    logic [3:0]  be_w;
    logic [31:0] steered_w;
    logic [31:0] load_w;

    assign ea        = req_base + {{16{req_offset[15]}}, req_offset};
    assign req_ok    = op_is_legal(req_opcode) && addr_is_aligned(req_opcode, ea[1:0]);
    assign issuing   = (state == ST_ISSUE);
    assign timed_out = issuing && !mem_ack && (cnt == CNT_LAST);

    lsu_align u_align (
        .opcode       (op_q),
        .byte_sel     (addr_q[1:0]),
        .store_data   (wdata_q),
        .load_word    (mem_rdata),
        .be           (be_w),
        .steered_data (steered_w),
        .load_data    (load_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (req_valid) state_n = req_ok ? ST_ISSUE : ST_RESP;
            ST_ISSUE: if (mem_ack || timed_out) state_n = ST_RESP;
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; the counter only advances while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_opcode;
                        addr_q  <= ea;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= !req_ok;
                        cnt     <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        rdata_q <= op_is_store(op_q) ? 32'h0 : load_w;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timed_out) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign mem_req    = issuing;
    assign mem_we     = issuing && op_is_store(op_q);
    assign mem_addr   = issuing ? addr_q[31:2] : '0;
    assign mem_be     = issuing ? be_w : '0;
    assign mem_wdata  = issuing ? steered_w : '0;
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued when a request is
// driven and popped by a response monitor; each test task also checks the memory side.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } resp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] base;
        logic [15:0] off;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wdx;
        logic [29:0] addr;
        logic [31:0] rdx;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_base;
    logic [15:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int    n_cmp = 0;
    int    n_bad = 0;
    resp_t exp_q[$];
    resp_t mon_exp;

    int          req_cycles;
    logic        stable;
    logic        seen_we;
    logic [29:0] seen_addr;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Response monitor: every resp_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (resp_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h error=%b, required no response",
                             resp_rdata, resp_error);
                end else begin
                    mon_exp = exp_q.pop_front();
                    n_cmp++;
                    if (resp_rdata !== mon_exp.rdata) begin
                        n_bad++;
                        $display("FAIL resp_rdata: got %h required %h", resp_rdata, mon_exp.rdata);
                    end
                    n_cmp++;
                    if (resp_error !== mon_exp.error) begin
                        n_bad++;
                        $display("FAIL resp_error: got %b required %b", resp_error, mon_exp.error);
                    end
                end
            end else begin
                n_cmp++;
                if ({resp_rdata, resp_error} !== 33'd0) begin
                    n_bad++;
                    $display("FAIL resp_quiet: got rdata=%h error=%b with resp_valid=%b, required zeros",
                             resp_rdata, resp_error, resp_valid);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] op, input logic [31:0] base,
                          input logic [15:0] off, input logic [31:0] wd);
        req_opcode = op;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        req_opcode = 6'h3F;
        req_base   = $urandom;
        req_offset = 16'($urandom);
        req_wdata  = $urandom;
    endtask

    // Plays the memory: records the first-cycle request, tracks stability, acks on cycle ack_at.
    task automatic serve(input int ack_at, input logic [31:0] rd);
        req_cycles = 0;
        stable     = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (mem_req !== 1'b1) break;
            if (k == 0) begin
                seen_we    = mem_we;
                seen_addr  = mem_addr;
                seen_be    = mem_be;
                seen_wdata = mem_wdata;
            end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {seen_we, seen_addr, seen_be, seen_wdata}) begin
                stable = 1'b0;
            end
            req_cycles++;
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({req_ready, mem_req, resp_valid, mem_we} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready/req/valid/we=%b required 1000",
                     {req_ready, mem_req, resp_valid, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_be, mem_wdata, resp_rdata, resp_error} !== 99'd0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h be=%h wdata=%h rdata=%h err=%b required all 0",
                     mem_addr, mem_be, mem_wdata, resp_rdata, resp_error);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_word();
        exp_q.push_back('{rdata: 32'h0, error: 1'b0});
        accept(6'h2B, 32'h0000_0100, 16'h0004, 32'hDEAD_BEEF);
        serve(2, 32'h5555_5555);
        n_cmp++;
        if (req_cycles !== 3) begin
            n_bad++;
            $display("FAIL sw_req_cycles: got %0d required 3", req_cycles);
        end
        n_cmp++;
        if ({seen_we, seen_addr, seen_be, seen_wdata} !== {1'b1, 30'h41, 4'hF, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL sw_mem_fields: got we=%b addr=%h be=%h wdata=%h required 1 41 f deadbeef",
                     seen_we, seen_addr, seen_be, seen_wdata);
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_stable: got stable=%b required 1", stable);
        end
        n_cmp++;
        if ({resp_valid, mem_req, req_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL sw_resp_cycle: got valid/req/ready=%b required 100", {resp_valid, mem_req, req_ready});
        end
        tick();
        n_cmp++;
        if (exp_q.size() != 0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_done: got pending=%0d ready=%b required 0 1", exp_q.size(), req_ready);
        end
    endtask

    task automatic test_steering();
        vec_t v[8];
        v[0] = '{6'h20, 32'h200,      16'h0003, 32'h0,         32'h80AA_BBCC, 4'hF, 32'h0,         30'h80,  32'hFFFF_FF80};
        v[1] = '{6'h24, 32'h200,      16'h0003, 32'h0,         32'h80AA_BBCC, 4'hF, 32'h0,         30'h80,  32'h0000_0080};
        v[2] = '{6'h29, 32'h20,       16'hFFF2, 32'h0000_ABCD, 32'h0,         4'hC, 32'hABCD_ABCD, 30'h4,   32'h0};
        v[3] = '{6'h25, 32'h10,       16'h0002, 32'h0,         32'hABCD_1234, 4'hF, 32'h0,         30'h4,   32'h0000_ABCD};
        v[4] = '{6'h21, 32'h10,       16'h0000, 32'h0,         32'h1234_8001, 4'hF, 32'h0,         30'h4,   32'hFFFF_8001};
        v[5] = '{6'h28, 32'h100,      16'h0001, 32'h0000_55AA, 32'h0,         4'h2, 32'hAAAA_AAAA, 30'h40,  32'h0};
        v[6] = '{6'h23, 32'hFFFF_FFFC,16'h0008, 32'h0,         32'hCAFE_F00D, 4'hF, 32'h0,         30'h1,   32'hCAFE_F00D};
        v[7] = '{6'h2B, 32'h1000,     16'hFFFC, 32'h0123_4567, 32'h0,         4'hF, 32'h0123_4567, 30'h3FF, 32'h0};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{rdata: v[i].rdx, error: 1'b0});
            accept(v[i].op, v[i].base, v[i].off, v[i].wd);
            serve(i % 3, v[i].rd);
            n_cmp++;
            if (req_cycles !== (i % 3) + 1 || stable !== 1'b1) begin
                n_bad++;
                $display("FAIL steer_cycles[%0d]: got cycles=%0d stable=%b required %0d 1",
                         i, req_cycles, stable, (i % 3) + 1);
            end
            n_cmp++;
            if ({seen_we, seen_addr, seen_be} !== {v[i].op[3], v[i].addr, v[i].be}) begin
                n_bad++;
                $display("FAIL steer_fields[%0d]: got we=%b addr=%h be=%b required %b %h %b",
                         i, seen_we, seen_addr, seen_be, v[i].op[3], v[i].addr, v[i].be);
            end
            if (v[i].op[3]) begin
                n_cmp++;
                if (seen_wdata !== v[i].wdx) begin
                    n_bad++;
                    $display("FAIL steer_wdata[%0d]: got %h required %h", i, seen_wdata, v[i].wdx);
                end
            end
            tick();
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL steer_resp[%0d]: got %0d pending required 0", i, exp_q.size());
            end
        end
    endtask

    task automatic test_errors();
        logic [5:0]  ops[6];
        logic [31:0] bases[6];
        ops[0] = 6'h23; bases[0] = 32'h6;
        ops[1] = 6'h3F; bases[1] = 32'h0;
        ops[2] = 6'h21; bases[2] = 32'h1;
        ops[3] = 6'h2B; bases[3] = 32'h102;
        ops[4] = 6'h25; bases[4] = 32'h3;
        ops[5] = 6'h22; bases[5] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{rdata: 32'h0, error: 1'b1});
            accept(ops[i], bases[i], 16'h0, 32'hFFFF_FFFF);
            n_cmp++;
            if ({resp_valid, mem_req, req_ready} !== 3'b100) begin
                n_bad++;
                $display("FAIL err_resp_cycle[%0d]: got valid/req/ready=%b required 100",
                         i, {resp_valid, mem_req, req_ready});
            end
            tick();
            n_cmp++;
            if (exp_q.size() != 0 || mem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL err_done[%0d]: got pending=%0d mem_req=%b required 0 0",
                         i, exp_q.size(), mem_req);
            end
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back('{rdata: 32'h0, error: 1'b1});
        accept(6'h23, 32'h40, 16'h0, 32'h0);
        serve(-1, 32'h0);
        n_cmp++;
        if (req_cycles !== 4) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d required 4", req_cycles);
        end
        n_cmp++;
        if ({resp_valid, mem_req} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_resp_cycle: got valid/req=%b required 10", {resp_valid, mem_req});
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        tick();
        n_cmp++;
        if ({mem_req, resp_valid, req_ready} !== 3'b001 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_late_ack: got req/valid/ready=%b pending=%0d required 001 0",
                     {mem_req, resp_valid, req_ready}, exp_q.size());
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        logic [15:0] off;
        logic [31:0] ea;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            base = $urandom & 32'hFFFF_FFFC;
            off  = 16'($urandom) & 16'hFFFC;
            rd   = $urandom;
            ea   = base + {{16{off[15]}}, off};
            exp_q.push_back('{rdata: rd, error: 1'b0});
            accept(6'h23, base, off, 32'h0);
            serve(0, rd);
            n_cmp++;
            if (req_cycles !== 1 || seen_addr !== ea[31:2] || resp_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_lw[%0d]: got cycles=%0d addr=%h valid=%b required 1 %h 1",
                         i, req_cycles, seen_addr, resp_valid, ea[31:2]);
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_issue();
        accept(6'h23, 32'h300, 16'h0, 32'h0);
        tick();
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_issue_pre: got mem_req=%b required 1", mem_req);
        end
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
        tick();
        n_cmp++;
        if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL rst_issue_drop: got req/valid/ready=%b required 001", {mem_req, resp_valid, req_ready});
        end
        rst     = 1'b0;
        mem_ack = 1'b0;
        tick();
        exp_q.push_back('{rdata: 32'h1122_3344, error: 1'b0});
        accept(6'h23, 32'h304, 16'h0, 32'h0);
        serve(0, 32'h1122_3344);
        n_cmp++;
        if (req_cycles !== 1 || seen_addr !== 30'hC1 || seen_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_next_lw: got cycles=%0d addr=%h we=%b required 1 c1 0",
                     req_cycles, seen_addr, seen_we);
        end
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rst_next_resp: got %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_opcode = 6'h0;
        req_base   = 32'h0;
        req_offset = 16'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_store_word();
        test_steering();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_issue();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles mem_req may wait for mem_ack before an error response.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 req_valid  in  1  CPU presents a memory instruction.
REQ-005 req_ready  out  1  LSU can accept; high only in IDLE.
REQ-006 req_opcode  in  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
REQ-007 req_base  in  32  base register value.
REQ-008 req_offset  in  16  immediate; sign-extended before add.
REQ-009 req_wdata  in  32  store source register value.
REQ-010 resp_valid  out  1  one-cycle pulse: load data or store completion.
REQ-011 resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-012 resp_error  out  1  valid with resp_valid: misalign, bad opcode or timeout.
REQ-013 mem_req  out  1  memory access request, held until mem_ack.
REQ-014 mem_we  out  1  1 = store, 0 = load.
REQ-015 mem_addr  out  30  word address (effective address [31:2]).
REQ-016 mem_be  out  4  byte enables; lane k = bits 8k+7:8k (little-endian).
REQ-017 mem_wdata  out  32  lane-steered store data.
REQ-018 mem_ack  in  1  memory completes access in the cycle it is high.
REQ-019 mem_rdata  in  32  read word, valid with mem_ack on loads.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-021 Handshake: accept when req_valid && req_ready; opcode, effective address (base + sext(offset), mod 2^32) and wdata SHALL be registered at acceptance; later input changes ignored.
REQ-022 IDLE -> ISSUE on a legal aligned request; IDLE -> RESP with resp_error=1 on misalign or unlisted opcode, no memory access.
REQ-023 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; LB/LBU/SB always aligned.
REQ-024 ISSUE: mem_req=1 with stable mem_we/addr/be/wdata; first ISSUE cycle is the cycle after acceptance.
REQ-025 ISSUE -> RESP on mem_ack; load data captured from mem_rdata that cycle.
REQ-026 Timeout counter SHALL clear on entering ISSUE, increment per ISSUE cycle without ack; on reaching TIMEOUT_CYCLES go to RESP with resp_error=1, mem_req dropped.
REQ-027 RESP lasts exactly one cycle with resp_valid=1, then IDLE; minimum accept-to-resp_valid latency 2 cycles (ack in first ISSUE cycle).
REQ-028 mem_ack outside ISSUE SHALL be ignored.
REQ-029 Store steering: SB replicates byte to all lanes, be=1<<addr[1:0]; SH replicates halfword, be=0011 (addr[1]=0) or 1100; SW be=1111; loads be=1111.
REQ-030 Load extraction: selected byte/halfword from lane addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-031 All outputs except resp_* in IDLE/RESP SHALL be 0; resp_rdata/resp_error 0 when resp_valid=0.

Reset
REQ-032 rst SHALL force IDLE, counter 0, mem_req=0, resp_valid=0, req_ready=1 (from next cycle), all data outputs 0.
REQ-033 rst mid-ISSUE SHALL drop mem_req on the same edge with no response generated; pending ack ignored.

Structure
REQ-034 Opcode constants, state encoding and the be/lane mapping constants SHALL live in a shared package mips_mem_pkg.
REQ-035 Lane steering/extension SHALL be one combinational sub-module lsu_align (store steer + load extract); FSM and counter in the top.

Verification
REQ-036 SW base=0x100, off=4, wdata=0xDEADBEEF, ack after 3 cycles -> mem_addr=0x41, be=1111, wdata=0xDEADBEEF held 3 cycles; resp_valid, error=0.
REQ-037 LB addr 0x203, mem_rdata=0x80AABBCC -> be=1111, resp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x12, wdata=0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD; LHU addr 0x12, rdata=0xABCD1234 -> 0x0000ABCD.
REQ-039 LW addr 0x6 and opcode 0x3F -> no mem_req, resp_valid 2nd cycle after acceptance with error=1, rdata=0.
REQ-040 TIMEOUT_CYCLES=4, LW with no ack -> mem_req for 4 cycles then resp error=1; late ack ignored.
REQ-041 rst asserted in 2nd ISSUE cycle -> mem_req 0 next cycle, no resp_valid, req_ready=1, next LW completes normally.
